if_prefetch_buf: RTL

//   Instruction-fetch front end for the 5-stage pipeline: owns the fetch PC, issues

---
 rtl/if_prefetch_buf.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/if_prefetch_buf.sv
// -----------------------------------------------------------------------------
// if_prefetch_buf
//   Instruction-fetch front end. Owns the fetch PC, issues one request at a
//   time to a variable-latency instruction memory, and buffers the returned
//   words in a small FIFO that feeds the IF/ID register over valid/ready.
//   A branch redirect flushes the FIFO and restarts fetching at redirect_pc;
//   a request already in flight at that moment is drained and its data dropped.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   redirect/_pc        flush and refetch from redirect_pc
//   halt                stop issuing new fetches (sticky until rst)
//   im_req/im_addr      memory request, held until im_ack
//   im_ack/im_rdata     memory response
//   if_valid/if_instr/if_pc_next/if_ready   FIFO head handshake to IF/ID
//   fetch_pc            address of the next/current request
//   full, empty         FIFO occupancy flags
// -----------------------------------------------------------------------------
module if_prefetch_buf #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [15:0] INCR     = 16'd1,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        halt,
  output logic        im_req,
  output logic [15:0] im_addr,
  input  logic        im_ack,
  input  logic [15:0] im_rdata,
  output logic        if_valid,
  output logic [15:0] if_instr,
  output logic [15:0] if_pc_next,
  input  logic        if_ready,
  output logic [15:0] fetch_pc,
  output logic        full,
  output logic        empty
);

  localparam int unsigned   AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned   CW      = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [15:0]   fetch_pc_q, fetch_pc_d;
  logic [15:0]   drain_addr_q, drain_addr_d;
  logic          halted_q, halted_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic          push_s, pop_s, issue_s;

  logic [15:0]   mem_instr_q [DEPTH];
  logic [15:0]   mem_pcn_q   [DEPTH];

  // Next-state, FIFO bookkeeping and fetch PC update.
  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    drain_addr_d = drain_addr_q;
    halted_d     = halted_q | halt;
    count_d      = count_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    push_s       = 1'b0;
    pop_s        = 1'b0;
    issue_s      = 1'b0;

    if (redirect) begin
      // Redirect wins over push/pop: the whole FIFO is discarded.
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      fetch_pc_d = redirect_pc;
      issue_s    = !halted_q;
      case (state_q)
        ST_IDLE: state_d = issue_s ? ST_WAIT : ST_IDLE;
        ST_WAIT: begin
          if (im_ack) begin
            state_d = issue_s ? ST_WAIT : ST_IDLE;
          end else begin
            // Keep the abandoned address on the bus until memory answers.
            state_d      = ST_DRAIN;
            drain_addr_d = fetch_pc_q;
          end
        end
        ST_DRAIN: begin
          if (im_ack) begin
            state_d = issue_s ? ST_WAIT : ST_IDLE;
          end else begin
            state_d = ST_DRAIN;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else begin
      pop_s   = (count_q != '0) && if_ready;
      push_s  = (state_q == ST_WAIT) && im_ack;
      count_d = count_q + CW'(push_s) - CW'(pop_s);
      if (push_s) begin
        wr_ptr_d   = wr_ptr_q + AW'(1);
        fetch_pc_d = fetch_pc_q + INCR;
      end else begin
        wr_ptr_d   = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      // Counting against count_d reserves a slot for the outstanding word.
      issue_s = (count_d < DEPTH_C) && !halted_q;
      case (state_q)
        ST_IDLE: state_d = issue_s ? ST_WAIT : ST_IDLE;
        ST_WAIT: begin
          if (im_ack) begin
            state_d = issue_s ? ST_WAIT : ST_IDLE;
          end else begin
            state_d = ST_WAIT;
          end
        end
        ST_DRAIN: begin
          if (im_ack) begin
            state_d = halted_q ? ST_IDLE : ST_WAIT;
          end else begin
            state_d = ST_DRAIN;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Control and pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      fetch_pc_q   <= RESET_PC;
      drain_addr_q <= 16'h0000;
      halted_q     <= 1'b0;
      count_q      <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      drain_addr_q <= drain_addr_d;
      halted_q     <= halted_d;
      count_q      <= count_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
    end
  end

  // FIFO storage; only the pointers/count need reset.
  always_ff @(posedge clk) begin
    if (!rst && push_s) begin
      mem_instr_q[wr_ptr_q] <= im_rdata;
      mem_pcn_q[wr_ptr_q]   <= fetch_pc_q + INCR;
    end
  end

  assign im_req     = (state_q != ST_IDLE);
  assign im_addr    = (state_q == ST_DRAIN) ? drain_addr_q : fetch_pc_q;
  assign if_valid   = (count_q != '0);
  assign if_instr   = if_valid ? mem_instr_q[rd_ptr_q] : 16'h0000;
  assign if_pc_next = if_valid ? mem_pcn_q[rd_ptr_q]   : 16'h0000;
  assign fetch_pc   = fetch_pc_q;
  assign full       = (count_q == DEPTH_C);
  assign empty      = (count_q == '0);

endmodule
